// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state codes, which
// double as the debug owner codes, and default memory geometry.
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_OWN0 = 2'b01;
  localparam state_t ST_OWN1 = 2'b10;

  function automatic state_t own_state(input logic port);
    return port ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register of {valid, tag} that tracks in-flight reads so
// each memory result is steered back to the port that issued it.
module arb_rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_tag,
  output logic out_valid,
  output logic out_tag
);

  logic [RD_LAT-1:0] valid_sr;
  logic [RD_LAT-1:0] tag_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      tag_sr   <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      tag_sr[0]   <= in_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        tag_sr[i]   <= tag_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[RD_LAT-1];
  assign out_tag   = tag_sr[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the core (port 0) and the
// loader/debug port (port 1) with round-robin tie-break and bounded hold.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk_50MHz,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_address,
  output logic          mem_wren,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_q,
  output logic [1:0]    owner
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t        state;
  state_t        state_nxt;
  logic          rr_ptr;
  logic [HW-1:0] hold_cnt;
  logic          acc0;
  logic          acc1;
  logic          hold_done;
  logic          pipe_valid;
  logic          pipe_tag;

  assign acc0      = (state == ST_OWN0) && req0;
  assign acc1      = (state == ST_OWN1) && req1;
  assign hold_done = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req0 && req1)  state_nxt = own_state(rr_ptr);
        else if (req0)     state_nxt = ST_OWN0;
        else if (req1)     state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (!req0)                  state_nxt = req1 ? ST_OWN1 : ST_IDLE;
        else if (req1 && hold_done) state_nxt = ST_OWN1;
      end
      ST_OWN1: begin
        if (!req1)                  state_nxt = req0 ? ST_OWN0 : ST_IDLE;
        else if (req0 && hold_done) state_nxt = ST_OWN0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // hold_cnt saturates so a long uncontested run still hands over promptly
  // once the other port starts requesting.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        hold_cnt <= '0;
        if (state_nxt == ST_OWN0)      rr_ptr <= 1'b1;
        else if (state_nxt == ST_OWN1) rr_ptr <= 1'b0;
      end else if ((acc0 || acc1) && !hold_done) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (acc0) begin
      mem_address = addr0;
      mem_data    = wdata0;
      mem_wren    = we0;
    end else if (acc1) begin
      mem_address = addr1;
      mem_data    = wdata1;
      mem_wren    = we1;
    end
  end

  arb_rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_tag_pipe (
    .clk      (clk_50MHz),
    .rst_n    (reset_n),
    .in_valid ((acc0 && !we0) || (acc1 && !we1)),
    .in_tag   (acc1),
    .out_valid(pipe_valid),
    .out_tag  (pipe_tag)
  );

  assign rvalid0 = pipe_valid && !pipe_tag;
  assign rvalid1 = pipe_valid && pipe_tag;
  assign rdata0  = mem_q;
  assign rdata1  = mem_q;
  assign gnt0    = (state == ST_OWN0);
  assign gnt1    = (state == ST_OWN1);
  assign owner   = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset corner cases and a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 16;
  localparam int RD_LAT   = 1;
  localparam int MAX_HOLD = 4;

  typedef struct {
    bit            r0;
    bit            w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    bit            r1;
    bit            w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    bit            g0;
    bit            g1;
    bit            wr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            v0;
    bit            v1;
    logic [DW-1:0] rd;
  } vec_t;

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } pend_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic          mem_wren;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;
  logic [1:0]    owner;

  logic [DW-1:0] ram [256];
  logic          ram_ready = 1'b0;
  logic [DW-1:0] shadow [256];

  int    tests_run    = 0;
  int    tests_failed = 0;
  int    cyc          = 0;
  int    m_owner      = 0;
  int    m_fav        = 1;
  int    m_run        = 0;
  bit    m_acc0_last  = 1'b0;
  bit    m_acc1_last  = 1'b0;
  pend_t pend[$];
  vec_t  vecs[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk_50MHz  (clk),
    .reset_n    (reset_n),
    .req0       (req0),
    .we0        (we0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .gnt0       (gnt0),
    .rvalid0    (rvalid0),
    .rdata0     (rdata0),
    .req1       (req1),
    .we1        (we1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .gnt1       (gnt1),
    .rvalid1    (rvalid1),
    .rdata1     (rdata1),
    .mem_address(mem_address),
    .mem_wren   (mem_wren),
    .mem_data   (mem_data),
    .mem_q      (mem_q),
    .owner      (owner)
  );

  function automatic logic [DW-1:0] initVal(input int a);
    return (a == 'h10) ? 16'hBEEF : (16'h1000 | 16'(a));
  endfunction

  // Single-port synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= initVal(i);
      ram_ready <= 1'b1;
      mem_q     <= '0;
    end else begin
      if (mem_wren) ram[mem_address] <= mem_data;
      mem_q <= ram[mem_address];
    end
  end

  function automatic vec_t mk(bit r0, bit w0, logic [7:0] a0, logic [15:0] d0,
                              bit r1, bit w1, logic [7:0] a1, logic [15:0] d1,
                              bit g0, bit g1, bit wr, logic [7:0] ea, logic [15:0] ed,
                              bit v0, bit v1, logic [15:0] rd);
    vec_t v;
    v = '{r0, w0, a0, d0, r1, w1, a1, d1, g0, g1, wr, ea, ed, v0, v1, rd};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (model cycle %0d, t=%0t)", name, actual, expected, cyc, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    #1;
  endtask

  task automatic modelReset();
    m_owner = 0;
    m_fav   = 1;
    m_run   = 0;
    m_acc0_last = 1'b0;
    m_acc1_last = 1'b0;
    pend.delete();
  endtask

  // Reference model: who owns the memory, what it sees, what comes back when.
  task automatic modelCheck();
    bit            a0, a1, ev0, ev1;
    logic [AW-1:0] ea;
    bit            ewr;
    a0  = (m_owner == 1) && req0;
    a1  = (m_owner == 2) && req1;
    ea  = a0 ? addr0 : (a1 ? addr1 : '0);
    ewr = a0 ? we0 : (a1 ? we1 : 1'b0);
    ev0 = (pend.size() > 0) && (pend[0].due == cyc) && (pend[0].port == 0);
    ev1 = (pend.size() > 0) && (pend[0].due == cyc) && (pend[0].port == 1);
    checkOutput("gnt0", gnt0, m_owner == 1);
    checkOutput("gnt1", gnt1, m_owner == 2);
    checkOutput("owner", owner, m_owner);
    checkOutput("mem_wren", mem_wren, ewr);
    checkOutput("mem_address", mem_address, ea);
    if (a0 || a1) checkOutput("mem_data", mem_data, a0 ? wdata0 : wdata1);
    checkOutput("rvalid0", rvalid0, ev0);
    checkOutput("rvalid1", rvalid1, ev1);
    if (ev0) checkOutput("rdata0", rdata0, pend[0].data);
    if (ev1) checkOutput("rdata1", rdata1, pend[0].data);
  endtask

  task automatic modelAdvance();
    bit            a0, a1, mine, other;
    int            nxt, port;
    logic [AW-1:0] a;
    a0 = (m_owner == 1) && req0;
    a1 = (m_owner == 2) && req1;
    if ((pend.size() > 0) && (pend[0].due == cyc)) void'(pend.pop_front());
    if (a0 || a1) begin
      port = a1 ? 1 : 0;
      a    = a1 ? addr1 : addr0;
      if ((a1 ? we1 : we0) == 1'b0) pend.push_back('{cyc + RD_LAT, port, shadow[a]});
      else shadow[a] = a1 ? wdata1 : wdata0;
      m_run++;
    end
    nxt = m_owner;
    if (m_owner == 0) begin
      if (req0 && req1) nxt = (m_fav == 1) ? 1 : 2;
      else if (req0)    nxt = 1;
      else if (req1)    nxt = 2;
    end else begin
      mine  = (m_owner == 1) ? req0 : req1;
      other = (m_owner == 1) ? req1 : req0;
      if (!mine)                         nxt = other ? 3 - m_owner : 0;
      else if (other && m_run >= MAX_HOLD) nxt = 3 - m_owner;
    end
    if (nxt != m_owner) begin
      m_run = 0;
      if (nxt != 0) m_fav = 3 - nxt;
    end
    m_owner     = nxt;
    m_acc0_last = a0;
    m_acc1_last = a1;
    cyc++;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 8'h55; addr1 = 8'h66; wdata0 = 16'hAAAA; wdata1 = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checkOutput("reset_gnt", {gnt1, gnt0}, 0);
      checkOutput("reset_rvalid", {rvalid1, rvalid0}, 0);
      checkOutput("reset_wren", mem_wren, 0);
      checkOutput("reset_addr", mem_address, 0);
      checkOutput("reset_owner", owner, 0);
    end
    reset_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    modelReset();
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) shadow[i] = initVal(i);

    // Tie-break after reset, then alternation from IDLE.
    vecs.push_back(mk(1,0,8'h01,0, 1,0,8'h02,0, 0,0,0,8'h00,0, 0,0,0));
    vecs.push_back(mk(1,0,8'h01,0, 0,0,8'h00,0, 1,0,0,8'h01,0, 0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0, 1,0,0,8'h00,0, 1,0,16'h1001));
    vecs.push_back(mk(1,0,8'h03,0, 1,0,8'h04,0, 0,0,0,8'h00,0, 0,0,0));
    vecs.push_back(mk(1,0,8'h03,0, 1,0,8'h04,0, 0,1,0,8'h04,0, 0,0,0));
    vecs.push_back(mk(1,0,8'h03,0, 0,0,8'h00,0, 0,1,0,8'h00,0, 0,1,16'h1004));
    vecs.push_back(mk(1,0,8'h03,0, 0,0,8'h00,0, 1,0,0,8'h03,0, 0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0, 1,0,0,8'h00,0, 1,0,16'h1003));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,8'h00,0, 0,0,0));
    // Single read of 8'h10.
    vecs.push_back(mk(1,0,8'h10,0, 0,0,8'h00,0, 0,0,0,8'h00,0, 0,0,0));
    vecs.push_back(mk(1,0,8'h10,0, 0,0,8'h00,0, 1,0,0,8'h10,0, 0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0, 1,0,0,8'h00,0, 1,0,16'hBEEF));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,8'h00,0, 0,0,0));
    // Contention: four port-0 accesses, then hand-over with in-flight return.
    vecs.push_back(mk(1,0,8'h30,0, 0,0,8'h00,0, 0,0,0,8'h00,0, 0,0,0));
    vecs.push_back(mk(1,0,8'h30,0, 1,0,8'h40,0, 1,0,0,8'h30,0, 0,0,0));
    vecs.push_back(mk(1,0,8'h31,0, 1,0,8'h40,0, 1,0,0,8'h31,0, 1,0,16'h1030));
    vecs.push_back(mk(1,0,8'h32,0, 1,0,8'h40,0, 1,0,0,8'h32,0, 1,0,16'h1031));
    vecs.push_back(mk(1,0,8'h33,0, 1,0,8'h40,0, 1,0,0,8'h33,0, 1,0,16'h1032));
    vecs.push_back(mk(1,0,8'h34,0, 1,0,8'h40,0, 0,1,0,8'h40,0, 1,0,16'h1033));
    vecs.push_back(mk(1,0,8'h34,0, 0,0,8'h00,0, 0,1,0,8'h00,0, 0,1,16'h1040));
    vecs.push_back(mk(1,0,8'h34,0, 0,0,8'h00,0, 1,0,0,8'h34,0, 0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0, 1,0,0,8'h00,0, 1,0,16'h1034));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,8'h00,0, 0,0,0));
    // Port 1 writes 8'h20, port 0 reads it back.
    vecs.push_back(mk(0,0,8'h00,0, 1,1,8'h20,16'h1234, 0,0,0,8'h00,0, 0,0,0));
    vecs.push_back(mk(1,0,8'h20,0, 1,1,8'h20,16'h1234, 0,1,1,8'h20,16'h1234, 0,0,0));
    vecs.push_back(mk(1,0,8'h20,0, 0,0,8'h00,0, 0,1,0,8'h00,0, 0,0,0));
    vecs.push_back(mk(1,0,8'h20,0, 0,0,8'h00,0, 1,0,0,8'h20,0, 0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0, 1,0,0,8'h00,0, 1,0,16'h1234));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,8'h00,0, 0,0,0));

    doReset();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_gnt", i), {gnt1, gnt0}, {vecs[i].g1, vecs[i].g0});
      checkOutput($sformatf("vec%0d_owner", i), owner, {vecs[i].g1, vecs[i].g0});
      checkOutput($sformatf("vec%0d_wren", i), mem_wren, vecs[i].wr);
      checkOutput($sformatf("vec%0d_addr", i), mem_address, vecs[i].ea);
      if (vecs[i].wr) checkOutput($sformatf("vec%0d_wdata", i), mem_data, vecs[i].ed);
      checkOutput($sformatf("vec%0d_rvalid", i), {rvalid1, rvalid0}, {vecs[i].v1, vecs[i].v0});
      if (vecs[i].v0) checkOutput($sformatf("vec%0d_rdata0", i), rdata0, vecs[i].rd);
      if (vecs[i].v1) checkOutput($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].rd);
      modelAdvance();
    end

    // Reset right after a read is clocked in: its rvalid must never appear.
    v = mk(1,0,8'h10,0, 0,0,8'h00,0, 0,0,0,8'h00,0, 0,0,0);
    applyStimulus(v);
    modelCheck();
    modelAdvance();
    applyStimulus(v);
    modelCheck();
    modelAdvance();
    @(posedge clk); #1;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checkOutput("flush_rvalid0", rvalid0, 0);
      checkOutput("flush_gnt0", gnt0, 0);
      checkOutput("flush_owner", owner, 0);
    end
    reset_n = 1'b1;
    req0 = 1'b0;
    modelReset();
    @(negedge clk); #1;
    checkOutput("post_flush_rvalid0", rvalid0, 0);
    checkOutput("post_flush_owner", owner, 0);

    doReset();
    v = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0);
    for (int n = 0; n < 3000; n++) begin
      if (!req0 || m_acc0_last) begin
        v.r0 = ($urandom_range(0, 9) < 6);
        v.w0 = ($urandom_range(0, 3) == 0);
        v.a0 = 8'($urandom_range(0, 15));
        v.d0 = 16'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        v.r0 = 1'b0;
      end
      if (!req1 || m_acc1_last) begin
        v.r1 = ($urandom_range(0, 9) < 6);
        v.w1 = ($urandom_range(0, 2) == 0);
        v.a1 = 8'($urandom_range(0, 15));
        v.d1 = 16'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        v.r1 = 1'b0;
      end
      applyStimulus(v);
      modelCheck();
      checkOutput("rvalid_exclusive", rvalid0 & rvalid1, 0);
      modelAdvance();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
